// File: rtl/game_pkg.sv
// Shared definitions for the game round timer: FSM state encodings, BCD limits
// and a BCD-to-binary helper used for the warning threshold comparison.
package game_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE    = 2'd0,
    TMR_RUN     = 2'd1,
    TMR_PAUSE   = 2'd2,
    TMR_EXPIRED = 2'd3
  } tmr_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Two BCD digits (each 0..9) to a binary value 0..99.
  function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
    return (7'(tens) * 7'd10) + 7'(ones);
  endfunction

endpackage

// File: rtl/game_countdown_timer_tick_prescaler.sv
// One-second tick generator: a down-counter that fires on its terminal count
// while enabled and immediately restarts the next second.
module tick_prescaler #(
  parameter int CLOCK_FREQUENCY = 50000000
) (
  input  logic ClockIn,
  input  logic Resetn,
  input  logic Reload,
  input  logic Enable,
  output logic Tick
);

  localparam int CNT_W = $clog2(CLOCK_FREQUENCY);
  localparam logic [CNT_W-1:0] RELOAD_VALUE = CNT_W'(CLOCK_FREQUENCY - 1);

  logic [CNT_W-1:0] count_q;

  // A reload request always suppresses the tick so an abort never also decrements.
  assign Tick = Enable && !Reload && (count_q == '0);

  // Count down while enabled, hold otherwise; wrap to a full second at zero.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      count_q <= RELOAD_VALUE;
    end else if (Reload) begin
      count_q <= RELOAD_VALUE;
    end else if (Enable) begin
      if (count_q == '0) begin
        count_q <= RELOAD_VALUE;
      end else begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown timer: Start/Pause/Abort control FSM, two BCD digit registers
// feeding the HEX decoders, and the status flags consumed by the game FSM.
module game_countdown_timer
  import game_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int START_SECONDS   = 60,
  parameter int WARN_SECONDS    = 10
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Abort,
  output logic [3:0] OnesValue,
  output logic [3:0] TensValue,
  output logic       Running,
  output logic       Warning,
  output logic       SecondTick,
  output logic       TimeUp,
  output logic       Expired
);

  localparam logic [3:0] PRESET_TENS = 4'(START_SECONDS / 10);
  localparam logic [3:0] PRESET_ONES = 4'(START_SECONDS % 10);
  localparam logic [6:0] WARN_LIMIT  = 7'(WARN_SECONDS);

  tmr_state_e state_q;
  logic [3:0] ones_q, tens_q;
  logic [3:0] onesDec_d, tensDec_d;
  logic       secondTick_q, timeUp_q;
  logic       canStart, prescReload, prescEnable, tick;

  // Start only counts from IDLE or EXPIRED; in RUNNING/PAUSED it must not touch the phase.
  assign canStart    = Start && ((state_q == TMR_IDLE) || (state_q == TMR_EXPIRED));
  assign prescReload = Abort || canStart;
  assign prescEnable = (state_q == TMR_RUN);

  tick_prescaler #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
  ) u_prescaler (
    .ClockIn(ClockIn),
    .Resetn (Resetn),
    .Reload (prescReload),
    .Enable (prescEnable),
    .Tick   (tick)
  );

  // BCD decrement with borrow from tens; saturates at 00 so the digits never wrap.
  always_comb begin
    onesDec_d = ones_q;
    tensDec_d = tens_q;
    if (ones_q != 4'd0) begin
      onesDec_d = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      onesDec_d = BCD_MAX;
      tensDec_d = tens_q - 4'd1;
    end
  end

  // Control FSM plus digit registers and the one-cycle tick/time-up pulses.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= TMR_IDLE;
      ones_q       <= PRESET_ONES;
      tens_q       <= PRESET_TENS;
      secondTick_q <= 1'b0;
      timeUp_q     <= 1'b0;
    end else begin
      secondTick_q <= 1'b0;
      timeUp_q     <= 1'b0;
      if (Abort) begin
        state_q <= TMR_IDLE;
        ones_q  <= PRESET_ONES;
        tens_q  <= PRESET_TENS;
      end else if (canStart) begin
        state_q <= TMR_RUN;
        ones_q  <= PRESET_ONES;
        tens_q  <= PRESET_TENS;
      end else begin
        case (state_q)
          TMR_RUN: begin
            if (tick) begin
              ones_q       <= onesDec_d;
              tens_q       <= tensDec_d;
              secondTick_q <= 1'b1;
              if ((onesDec_d == 4'd0) && (tensDec_d == 4'd0)) begin
                timeUp_q <= 1'b1;
                state_q  <= TMR_EXPIRED;
              end else if (Pause) begin
                state_q <= TMR_PAUSE;
              end
            end else if (Pause) begin
              state_q <= TMR_PAUSE;
            end
          end
          TMR_PAUSE: begin
            if (!Pause) begin
              state_q <= TMR_RUN;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign OnesValue  = ones_q;
  assign TensValue  = tens_q;
  assign Running    = (state_q == TMR_RUN);
  assign Expired    = (state_q == TMR_EXPIRED);
  assign SecondTick = secondTick_q;
  assign TimeUp     = timeUp_q;
  assign Warning    = ((state_q == TMR_RUN) || (state_q == TMR_PAUSE)) &&
                      (bcd2bin(tens_q, ones_q) <= WARN_LIMIT);

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for the round timer with a 4-cycle second, 12 s preset and 10 s warning.
module tb_game_countdown_timer;

  localparam int CLOCK_FREQUENCY = 4;
  localparam int START_SECONDS   = 12;
  localparam int WARN_SECONDS    = 10;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic       start  = 1'b0;
  logic       pause  = 1'b0;
  logic       abort  = 1'b0;
  logic [3:0] onesValue, tensValue;
  logic       running, warning, secondTick, timeUp, expired;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       start;
    logic       pause;
    logic       abort;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       run;
    logic       warn;
    logic       tick;
    logic       tup;
    logic       expd;
  } vec_t;

  vec_t vecs[13];

  // Free-running 10-time-unit clock.
  always #5 clock = ~clock;

  game_countdown_timer #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
    .START_SECONDS  (START_SECONDS),
    .WARN_SECONDS   (WARN_SECONDS)
  ) dut (
    .ClockIn   (clock),
    .Resetn    (resetn),
    .Start     (start),
    .Pause     (pause),
    .Abort     (abort),
    .OnesValue (onesValue),
    .TensValue (tensValue),
    .Running   (running),
    .Warning   (warning),
    .SecondTick(secondTick),
    .TimeUp    (timeUp),
    .Expired   (expired)
  );

  // Digits must always be legal BCD outside reset.
  assert property (@(negedge clock) disable iff (!resetn) (onesValue <= 4'd9) && (tensValue <= 4'd9))
    else begin
      errors++;
      $display("[TB] FAIL bcdRange: got tens=%0d ones=%0d, want both <= 9", tensValue, onesValue);
    end

  // Drive one cycle of inputs, then land 1 time unit after the edge that sampled them.
  task automatic applyStimulus(input logic s, input logic p, input logic a);
    start = s;
    pause = p;
    abort = a;
    @(posedge clock);
    #1;
  endtask

  // Compare every output against hand-computed expectations.
  task automatic checkOutput(input string name, input int eOnes, input int eTens,
                             input logic eRun, input logic eWarn, input logic eTick,
                             input logic eTup, input logic eExp);
    logic [12:0] actV, expV;
    actV = {tensValue, onesValue, running, warning, secondTick, timeUp, expired};
    expV = {4'(eTens), 4'(eOnes), eRun, eWarn, eTick, eTup, eExp};
    checks++;
    if (actV !== expV) begin
      errors++;
      $display("[TB] FAIL %s: got tens=%0d ones=%0d run=%b warn=%b tick=%b timeUp=%b exp=%b, want tens=%0d ones=%0d run=%b warn=%b tick=%b timeUp=%b exp=%b",
               name, tensValue, onesValue, running, warning, secondTick, timeUp, expired,
               eTens, eOnes, eRun, eWarn, eTick, eTup, eExp);
    end
  endtask

  // One full second of countdown from (r+1) to r: three quiet cycles then the tick.
  task automatic runSecond(input string name, input int r);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput({name, "Hold"}, (r + 1) % 10, (r + 1) / 10, 1'b1, (r + 1) <= WARN_SECONDS, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput({name, "Tick"}, r % 10, r / 10, r != 0, (r != 0) && (r <= WARN_SECONDS), 1'b1, r == 0, r == 0);
  endtask

  initial begin
    // start pause abort | ones tens run warn tick timeUp expired
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state and release
    repeat (2) @(posedge clock);
    #1;
    checkOutput("resetState", 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("resetRelease", 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start, first tick after 4 cycles, warning boundary, ones borrow
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].start, vecs[i].pause, vecs[i].abort);
      checkOutput($sformatf("vec%0d", i), vecs[i].ones, vecs[i].tens, vecs[i].run,
                  vecs[i].warn, vecs[i].tick, vecs[i].tup, vecs[i].expd);
    end

    // Count down 09 -> 00 and expire
    for (int k = 8; k >= 0; k--) begin
      runSecond("countdown", k);
    end
    for (int j = 0; j < 20; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("expiredHold", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Restart from EXPIRED, then pause 10 cycles with prescaler frozen at 2
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restartExpired", 2, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("pauseHold", 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pauseRelease", 2, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 2; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("resumeWait", 2, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("resumeTick", 1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Tick and Pause in the same cycle: decrement happens, then PAUSED
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("preTickPause", 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("tickPause", 0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("tickPauseRelease", 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Start while RUNNING must not disturb the prescaler phase
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("startIgnored", 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 2; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("phaseWait", 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("phaseKept", 9, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Abort at 07, Abort with Start, Start with Pause from IDLE
    runSecond("toSeven", 8);
    runSecond("toSeven", 7);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abortRun", 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("abortStart", 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("abortIdle", 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("startPauseRun", 2, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("startPausePaused", 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("abortPaused", 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Count to 05 and apply reset between clock edges
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("startFresh", 2, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 11; r >= 5; r--) begin
      runSecond("toFive", r);
    end
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("asyncReset", 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    checkOutput("resetHold", 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("resetIdle", 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
